microwave_panel: RTL and testbench

- Front-panel controller that drives the oven timer core's time setpoint `tin` and run request `r`.
- Watches the core's power output `p` to track each cook cycle.
- Turns user button presses into a setpoint and a start/stop handshake, and beeps when the cook completes.
- Sits between the keypad logic (buttons already synchronised to `clk`) and the microwave timer core.

---
 rtl/microwave_panel_pkg.sv | 23 ++
 rtl/panel_edge.sv | 18 +
 rtl/microwave_panel.sv | 134 +++++++++++++
 tb/tb_microwave_panel.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/microwave_panel_pkg.sv
// Shared definitions for the microwave front-panel controller: state encoding,
// setpoint defaults and the shared ARM/DONE counter width.
package microwave_panel_pkg;

    localparam int         TW_DEF  = 4;
    localparam logic [3:0] MAX_SET = 4'd15;
    localparam int         CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        COOK = 2'd2,
        DONE = 2'd3
    } state_e;

    // Button index within the packed press vector
    localparam int BTN_UP    = 0;
    localparam int BTN_CLR   = 1;
    localparam int BTN_START = 2;
    localparam int BTN_STOP  = 3;
    localparam int NUM_BTN   = 4;

endpackage

// File: rtl/panel_edge.sv
// Registered rising-edge detector for one synchronised button level.
module panel_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= 1'b0;
        else      prev_q <= btn_i;
    end

    assign press_o = btn_i & ~prev_q;

endmodule

// File: rtl/microwave_panel.sv
// Front-panel controller: builds the time setpoint, handshakes run/power with
// the timer core, flags start timeouts and beeps on normal completion.
module microwave_panel
    import microwave_panel_pkg::*;
#(
    parameter int TW            = TW_DEF,
    parameter int BEEP_CYCLES   = 8,
    parameter int START_TIMEOUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_up,
    input  logic          btn_clr,
    input  logic          btn_start,
    input  logic          btn_stop,
    input  logic          p,
    output logic [TW-1:0] tin,
    output logic          r,
    output logic          beep,
    output logic          busy,
    output logic          fault
);

    localparam logic [TW-1:0]    SET_MAX   = {TW{1'b1}};
    localparam logic [TW-1:0]    SET_ONE   = TW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_lvl;
    logic [NUM_BTN-1:0] press;

    assign btn_lvl = {btn_stop, btn_start, btn_clr, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_edge
        panel_edge u_edge (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btn_lvl[i]),
            .press_o (press[i])
        );
    end

    state_e           state_q, state_d;
    logic [TW-1:0]    set_q,   set_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             fault_q, fault_d;
    logic             r_q,     r_d;
    logic             beep_q,  beep_d;
    logic             busy_q,  busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            set_q   <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            r_q     <= 1'b0;
            beep_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            r_q     <= r_d;
            beep_q  <= beep_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (press[BTN_STOP]) begin
                    fault_d = 1'b0;
                end else if (press[BTN_CLR]) begin
                    set_d = '0;
                end else if (press[BTN_START]) begin
                    // An empty setpoint swallows the start (and any same-cycle up)
                    if (set_q != '0) begin
                        state_d = ARM;
                        fault_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (press[BTN_UP] && set_q != SET_MAX) begin
                    set_d = set_q + SET_ONE;
                end
            end
            ARM: begin
                cnt_d = cnt_q + CNT_ONE;
                if (press[BTN_STOP]) begin
                    state_d = IDLE;
                end else if (p) begin
                    state_d = COOK;
                end else if (cnt_q == ARM_LAST) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end
            end
            COOK: begin
                if (press[BTN_STOP]) begin
                    state_d = IDLE;
                end else if (!p) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                // p is ignored here; only stop or the beep timer end the tone
                cnt_d = cnt_q + CNT_ONE;
                if (press[BTN_STOP] || cnt_q == BEEP_LAST) begin
                    state_d = IDLE;
                    set_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        r_d    = (state_d == ARM) || (state_d == COOK);
        beep_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    assign tin   = set_q;
    assign r     = r_q;
    assign beep  = beep_q;
    assign busy  = busy_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_microwave_panel.sv
// Scoreboard bench for microwave_panel: stimulus queues expected outputs per
// cycle, an independent monitor pops and compares them after each edge.
module tb_microwave_panel;

    logic       clk;
    logic       rst;
    logic       btn_up, btn_clr, btn_start, btn_stop;
    logic       p;
    logic [3:0] tin;
    logic       r, beep, busy, fault;

    microwave_panel dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_clr   (btn_clr),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .p         (p),
        .tin       (tin),
        .r         (r),
        .beep      (beep),
        .busy      (busy),
        .fault     (fault)
    );

    localparam logic [3:0] B0 = 4'b0000;
    localparam logic [3:0] UP = 4'b0001;
    localparam logic [3:0] CL = 4'b0010;
    localparam logic [3:0] ST = 4'b0100;
    localparam logic [3:0] SP = 4'b1000;

    typedef struct {
        int         cyc;
        logic [7:0] vec;   // {tin, r, beep, busy, fault}
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: tin/r/beep/busy/fault got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                     nm, act[7:4], act[3], act[2], act[1], act[0],
                     req[7:4], req[3], req[2], req[1], req[0]);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            compare(e.name, {tin, r, beep, busy, fault}, e.vec);
        end
    end

    task automatic tick(input logic [3:0] b, input logic pv);
        @(negedge clk);
        {btn_stop, btn_start, btn_clr, btn_up} = b;
        p = pv;
    endtask

    task automatic expect1(input logic [3:0] t, input logic rr, input logic bp,
                           input logic bs, input logic ft, input string nm);
        exp_t e;
        e.cyc  = cyc + 1;
        e.vec  = {t, rr, bp, bs, ft};
        e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        {btn_stop, btn_start, btn_clr, btn_up} = B0;
        p = 1'b0;
        #3;
        compare("reset_state", {tin, r, beep, busy, fault}, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // 1: saturation, clear, start with empty setpoint
        for (int i = 0; i < 17; i++) begin
            tick(UP, 0); expect1((i + 1 > 15) ? 4'd15 : 4'(i + 1), 0, 0, 0, 0, "up_sat");
            tick(B0, 0);
        end
        tick(CL, 0); expect1(4'd0, 0, 0, 0, 0, "clr");
        tick(B0, 0);
        tick(ST, 0); expect1(4'd0, 0, 0, 0, 0, "start_zero_ign");
        tick(B0, 0);

        // 2: normal cook
        for (int i = 0; i < 3; i++) begin
            tick(UP, 0); tick(B0, 0);
        end
        tick(ST, 0); expect1(4'd3, 1, 0, 1, 0, "arm_r");
        tick(B0, 0); expect1(4'd3, 1, 0, 1, 0, "arm_wait");
        tick(B0, 1); expect1(4'd3, 1, 0, 1, 0, "cook_enter");
        tick(B0, 1); expect1(4'd3, 1, 0, 1, 0, "cook_run");
        tick(B0, 1); expect1(4'd3, 1, 0, 1, 0, "cook_past_timeout");
        tick(B0, 0); expect1(4'd3, 0, 1, 1, 0, "done_beep");
        for (int i = 0; i < 7; i++) begin
            tick(B0, 0); expect1(4'd3, 0, 1, 1, 0, "beep_hold");
        end
        tick(B0, 0); expect1(4'd0, 0, 0, 0, 0, "beep_end");

        // 3: start timeout and fault clear
        for (int i = 0; i < 5; i++) begin
            tick(UP, 0); tick(B0, 0);
        end
        tick(ST, 0); expect1(4'd5, 1, 0, 1, 0, "to_arm");
        for (int i = 0; i < 3; i++) begin
            tick(B0, 0); expect1(4'd5, 1, 0, 1, 0, "to_wait");
        end
        tick(B0, 0); expect1(4'd5, 0, 0, 0, 1, "timeout_fault");
        tick(SP, 0); expect1(4'd5, 0, 0, 0, 0, "stop_clr_fault");
        tick(B0, 0);

        // 4: stop wins over a same-cycle p fall
        tick(ST, 0); expect1(4'd5, 1, 0, 1, 0, "ab_arm");
        tick(B0, 1); expect1(4'd5, 1, 0, 1, 0, "ab_cook");
        tick(B0, 1); expect1(4'd5, 1, 0, 1, 0, "ab_run");
        tick(SP, 0); expect1(4'd5, 0, 0, 0, 0, "abort");
        tick(B0, 0); expect1(4'd5, 0, 0, 0, 0, "abort_no_beep");
        tick(B0, 0); expect1(4'd5, 0, 0, 0, 0, "abort_no_beep2");

        // 5: held button, up+clr, buttons during DONE
        tick(CL, 0); expect1(4'd0, 0, 0, 0, 0, "clr2");
        tick(B0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(UP, 0); expect1(4'd1, 0, 0, 0, 0, "hold_up");
        end
        tick(B0, 0); expect1(4'd1, 0, 0, 0, 0, "hold_release");
        tick(UP | CL, 0); expect1(4'd0, 0, 0, 0, 0, "up_clr");
        tick(B0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(UP, 0); tick(B0, 0);
        end
        tick(ST, 0); expect1(4'd2, 1, 0, 1, 0, "d_arm");
        tick(B0, 1); expect1(4'd2, 1, 0, 1, 0, "d_cook");
        tick(B0, 0); expect1(4'd2, 0, 1, 1, 0, "d_done");
        tick(ST, 0); expect1(4'd2, 0, 1, 1, 0, "done_start_ign");
        tick(UP, 0); expect1(4'd2, 0, 1, 1, 0, "done_up_ign");
        tick(SP, 0); expect1(4'd0, 0, 0, 0, 0, "done_stop");
        tick(B0, 0);

        // 6: async reset mid-cook
        tick(UP, 0); expect1(4'd1, 0, 0, 0, 0, "rs_up");
        tick(B0, 0);
        tick(ST, 0); expect1(4'd1, 1, 0, 1, 0, "rs_arm");
        tick(B0, 1); expect1(4'd1, 1, 0, 1, 0, "rs_cook");
        tick(B0, 1); expect1(4'd1, 1, 0, 1, 0, "rs_run");
        @(negedge clk);
        #2 rst = 1'b0;
        #1 compare("async_reset", {tin, r, beep, busy, fault}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        p = 1'b0;
        tick(B0, 0); expect1(4'd0, 0, 0, 0, 0, "post_reset");

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending got %0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
